// File: rtl/alu_pkg.sv
// Shared encodings for the ALU op sequencer: ALU op codes, main-control codes,
// funct fields, sequencer states and the decode result bundle.
package alu_pkg;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_NOR = 4'b1100;

    localparam logic [1:0] CTL_MEM = 2'b00;
    localparam logic [1:0] CTL_BR  = 2'b01;
    localparam logic [1:0] CTL_R   = 2'b10;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXEC    = 2'd1;
    localparam logic [1:0] ST_MUL_RUN = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef struct packed {
        logic [3:0] op;
        logic       is_mul;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of main-control ALUOp plus funct3/funct7 into an ALU op.
// MUL and illegal encodings report ADD so the ALU is never driven with anything else.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_ctl,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '{op: ALUOP_ADD, is_mul: 1'b0, illegal: 1'b1};
        case (i_ctl)
            CTL_MEM: o_dec = '{op: ALUOP_ADD, is_mul: 1'b0, illegal: 1'b0};
            CTL_BR:  o_dec = '{op: ALUOP_SUB, is_mul: 1'b0, illegal: 1'b0};
            CTL_R: begin
                if (i_funct7 == F7_BASE && i_funct3 == F3_ADD)
                    o_dec = '{op: ALUOP_ADD, is_mul: 1'b0, illegal: 1'b0};
                else if (i_funct7 == F7_BASE && i_funct3 == F3_AND)
                    o_dec = '{op: ALUOP_AND, is_mul: 1'b0, illegal: 1'b0};
                else if (i_funct7 == F7_BASE && i_funct3 == F3_OR)
                    o_dec = '{op: ALUOP_OR, is_mul: 1'b0, illegal: 1'b0};
                else if (i_funct7 == F7_ALT && i_funct3 == F3_ADD)
                    o_dec = '{op: ALUOP_SUB, is_mul: 1'b0, illegal: 1'b0};
                else if (i_funct7 == F7_MULDIV && i_funct3 == F3_ADD)
                    o_dec = '{op: ALUOP_ADD, is_mul: 1'b1, illegal: 1'b0};
                else
                    o_dec = '{op: ALUOP_ADD, is_mul: 1'b0, illegal: 1'b1};
            end
            default: o_dec = '{op: ALUOP_ADD, is_mul: 1'b0, illegal: 1'b1};
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives an external combinational ALU from registers; one request in flight, result held until out_ready.
// Latency after accept: 2 cycles to out_valid for single ops, MUL_ITER+1 for the shift-add MUL loop.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int MUL_ITER = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_aluop_ctl,
    input  logic [2:0]      in_funct3,
    input  logic [6:0]      in_funct7,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_res,
    output logic            out_zero,
    output logic            out_illegal
);

    localparam int CNT_W = $clog2(MUL_ITER + 1);

    logic [1:0]      r_state;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [3:0]      r_op;
    logic            r_ill;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_out_res;
    logic            r_out_zero;
    logic            r_out_ill;

    dec_t            w_dec;
    logic            w_mul_last;

    alu_decode u_decode (
        .i_ctl    (in_aluop_ctl),
        .i_funct3 (in_funct3),
        .i_funct7 (in_funct7),
        .o_dec    (w_dec)
    );

    assign w_mul_last  = (r_cnt == CNT_W'(MUL_ITER - 1));
    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out_res     = r_out_res;
    assign out_zero    = r_out_zero;
    assign out_illegal = r_out_ill;

    // Illegal requests leave the ALU parked on ADD 0,0 even in EXEC.
    always_comb begin
        alu_op = ALUOP_ADD;
        alu_a  = '0;
        alu_b  = '0;
        case (r_state)
            ST_EXEC: begin
                if (!r_ill) begin
                    alu_op = r_op;
                    alu_a  = r_a;
                    alu_b  = r_b;
                end
            end
            ST_MUL_RUN: begin
                alu_a = r_acc;
                alu_b = r_mplier[0] ? r_mcand : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= ALUOP_ADD;
            r_ill      <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_out_res  <= '0;
            r_out_zero <= 1'b0;
            r_out_ill  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_op     <= w_dec.op;
                        r_ill    <= w_dec.illegal;
                        r_acc    <= '0;
                        r_mcand  <= in_a;
                        r_mplier <= in_b;
                        r_cnt    <= '0;
                        r_state  <= w_dec.is_mul ? ST_MUL_RUN : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_out_res  <= r_ill ? '0 : alu_res;
                    r_out_zero <= r_ill ? 1'b1 : alu_zero;
                    r_out_ill  <= r_ill;
                    r_state    <= ST_DONE;
                end
                ST_MUL_RUN: begin
                    r_acc    <= alu_res;
                    r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_mul_last) begin
                        r_out_res  <= alu_res;
                        r_out_zero <= alu_zero;
                        r_out_ill  <= 1'b0;
                        r_state    <= ST_DONE;
                    end
                end
                default: begin
                    if (out_ready)
                        r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU plus an arithmetic reference for each request.
module tb_alu_op_sequencer;

    localparam int XLEN = 64;
    localparam int MUL_ITER = 64;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_aluop_ctl;
    logic [2:0]      in_funct3;
    logic [6:0]      in_funct7;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic            out_zero;
    logic            out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(.XLEN(XLEN), .MUL_ITER(MUL_ITER)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_aluop_ctl (in_aluop_ctl),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_res      (alu_res),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_zero     (out_zero),
        .out_illegal  (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The combinational 64-bit ALU that sits next to the sequencer.
    always_comb begin
        case (alu_op)
            4'b0000: alu_res = alu_a & alu_b;
            4'b0001: alu_res = alu_a | alu_b;
            4'b0010: alu_res = alu_a + alu_b;
            4'b0110: alu_res = alu_a - alu_b;
            4'b1100: alu_res = ~(alu_a | alu_b);
            default: alu_res = '0;
        endcase
        alu_zero = (alu_res == '0);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference: what the request means architecturally.
    task automatic ref_model(input logic [1:0] ctl, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [63:0] a, input logic [63:0] b,
                             output logic [63:0] res, output logic ill, output logic mul,
                             output logic [3:0] op);
        ill = 1'b0; mul = 1'b0; op = 4'b0010; res = '0;
        if (ctl == 2'b00) begin res = a + b; op = 4'b0010; end
        else if (ctl == 2'b01) begin res = a - b; op = 4'b0110; end
        else if (ctl == 2'b10 && f7 == 7'h00 && f3 == 3'b000) begin res = a + b; op = 4'b0010; end
        else if (ctl == 2'b10 && f7 == 7'h00 && f3 == 3'b111) begin res = a & b; op = 4'b0000; end
        else if (ctl == 2'b10 && f7 == 7'h00 && f3 == 3'b110) begin res = a | b; op = 4'b0001; end
        else if (ctl == 2'b10 && f7 == 7'h20 && f3 == 3'b000) begin res = a - b; op = 4'b0110; end
        else if (ctl == 2'b10 && f7 == 7'h01 && f3 == 3'b000) begin res = a * b; mul = 1'b1; end
        else ill = 1'b1;
    endtask

    task automatic txn(input logic [1:0] ctl, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] e_res;
        logic        e_ill, e_mul, e_zero;
        logic [3:0]  e_op;
        int          cyc;
        logic        non_add;
        ref_model(ctl, f3, f7, a, b, e_res, e_ill, e_mul, e_op);
        e_zero = e_ill ? 1'b1 : (e_res == 64'd0);

        @(negedge clk);
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_aluop_ctl = ctl; in_funct3 = f3; in_funct7 = f7; in_a = a; in_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
        chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
        if (!e_ill && !e_mul) begin
            chk("exec_op", {60'd0, alu_op}, {60'd0, e_op});
            chk("exec_a", alu_a, a);
            chk("exec_b", alu_b, b);
        end
        cyc = 0;
        non_add = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (alu_op != 4'b0010) non_add = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, e_mul ? MUL_ITER : 1);
        if (e_ill || e_mul) chk("only_add_used", {63'd0, non_add}, 64'd0);
        for (int i = 0; i <= hold; i++) begin
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("out_res", out_res, e_ill ? 64'd0 : e_res);
            chk("out_zero", {63'd0, out_zero}, {63'd0, e_zero});
            chk("out_illegal", {63'd0, out_illegal}, {63'd0, e_ill});
            chk("done_in_ready", {63'd0, in_ready}, 64'd0);
            chk("done_alu_op", {60'd0, alu_op}, 64'd2);
            if (i < hold) begin
                out_ready = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b0;
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("release_out_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        logic [1:0] ctl;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [63:0] a, b;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_aluop_ctl = 2'b00; in_funct3 = 3'b000; in_funct7 = 7'h00; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_res", out_res, 64'd0);
        chk("rst_out_zero", {63'd0, out_zero}, 64'd0);
        chk("rst_out_illegal", {63'd0, out_illegal}, 64'd0);
        chk("rst_alu_op", {60'd0, alu_op}, 64'd2);
        chk("rst_alu_a", alu_a, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        txn(2'b10, 3'b000, 7'h00, 64'd5, 64'd7, 3);
        txn(2'b10, 3'b000, 7'h20, 64'd9, 64'd9, 0);
        txn(2'b01, 3'b000, 7'h00, 64'd3, 64'd5, 0);
        txn(2'b10, 3'b111, 7'h00, 64'hF0F0, 64'hFF00, 1);
        txn(2'b10, 3'b110, 7'h00, 64'hF0F0, 64'hFF00, 0);
        txn(2'b10, 3'b000, 7'h01, 64'h1_0000_0001, 64'd3, 0);
        txn(2'b10, 3'b000, 7'h01, 64'h8000_0000_0000_0000, 64'd2, 0);
        txn(2'b11, 3'b000, 7'h00, 64'd1, 64'd2, 0);
        txn(2'b10, 3'b101, 7'h00, 64'd1, 64'd2, 0);
        txn(2'b00, 3'b011, 7'h55, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 10);

        // Reset in the middle of a MUL discards it.
        @(negedge clk);
        in_valid = 1'b1; in_aluop_ctl = 2'b10; in_funct3 = 3'b000; in_funct7 = 7'h01;
        in_a = 64'd12345; in_b = 64'd678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midmul_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midmul_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midmul_out_res", out_res, 64'd0);
        chk("midmul_out_illegal", {63'd0, out_illegal}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("midmul_stays_idle", {63'd0, out_valid}, 64'd0);
        end

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: begin ctl = 2'b00; f3 = 3'($urandom); f7 = 7'($urandom); end
                1: begin ctl = 2'b01; f3 = 3'($urandom); f7 = 7'($urandom); end
                2: begin ctl = 2'b10; f3 = 3'b111; f7 = 7'h00; end
                3: begin ctl = 2'b10; f3 = 3'b110; f7 = 7'h00; end
                4: begin ctl = 2'b10; f3 = 3'b000; f7 = 7'h20; end
                5: begin ctl = 2'b10; f3 = 3'b000; f7 = 7'h01; end
                6: begin ctl = 2'b10; f3 = 3'b000; f7 = 7'h00; end
                default: begin ctl = 2'($urandom); f3 = 3'($urandom); f7 = 7'($urandom); end
            endcase
            a = {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
            txn(ctl, f3, f7, a, b, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Initiator-side controller for the 64-bit combinational ALU. Accepts decoded instruction fields over a valid/ready handshake and translates them into the ALU's 4-bit aluop code. It drives the ALU operand and op ports from registers, then returns the registered result and zero flag over a second valid/ready handshake. MUL has no ALU opcode, so the sequencer runs it as a multi-cycle shift-add loop using the ALU's ADD operation.

Parameters:
XLEN, 64, operand/result width; must match the ALU.
MUL_ITER, XLEN, number of shift-add iterations for MUL.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  request valid
in_ready  out  1  sequencer can accept a request
in_aluop_ctl  in  2  main-control ALUOp: 00 load/store, 01 branch, 10 R-type, 11 reserved
in_funct3  in  3  instruction funct3
in_funct7  in  7  instruction funct7
in_a  in  XLEN  operand A
in_b  in  XLEN  operand B
alu_a  out  XLEN  to ALU a
alu_b  out  XLEN  to ALU b
alu_op  out  4  to ALU aluop
alu_res  in  XLEN  from ALU res
alu_zero  in  1  from ALU zero
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_res  out  XLEN  result
out_zero  out  1  zero flag of out_res
out_illegal  out  1  unsupported encoding; out_res=0, out_zero=1

Behaviour:
- ALU op codes: AND=0000, OR=0001, ADD=0010, SUB=0110, NOR=1100.
- Decode:
  - ctl 00 -> ADD; ctl 01 -> SUB.
  - ctl 10 with funct7=0000000: f3 000 ADD; f3 111 AND; f3 110 OR.
  - ctl 10 with funct7=0100000 and f3 000 -> SUB.
  - ctl 10 with funct7=0000001 and f3 000 -> MUL.
  - All other encodings, including ctl 11, are illegal.
- States: IDLE, EXEC, MUL_RUN, DONE.
  - IDLE: in_ready=1. On in_valid, latch a, b, decoded op and illegal flag. Go to EXEC, or to MUL_RUN for MUL.
  - EXEC: alu_a=a_q, alu_b=b_q, alu_op=op_q for exactly one cycle. Register alu_res and alu_zero into out_res and out_zero. Go to DONE.
  - Illegal request: skip ALU use in EXEC, force out_res=0, out_zero=1, out_illegal=1.
  - MUL_RUN: on entry acc=0, mcand=a_q, mplier=b_q, cnt=0. Each cycle: alu_op=ADD, alu_a=acc, alu_b = mplier[0] ? mcand : 0. Then acc<=alu_res, mcand<<=1 (drop MSB), mplier>>=1 (logical), cnt++.
  - MUL_RUN exit: after iteration MUL_ITER-1, out_res=final alu_res, out_zero=final alu_zero; go to DONE. Result is the low XLEN bits of the product; wrap-around is silent.
  - DONE: out_valid=1, outputs held stable. On out_ready go to IDLE. No accept in DONE (in_ready=0).
- Latency, with request accepted at edge N:
  - Non-MUL or illegal: out_valid high from cycle N+2.
  - MUL: out_valid high from N+1+MUL_ITER.
- Throughput: one request in flight; in_ready=0 in EXEC, MUL_RUN and DONE.
- out_ready is ignored outside DONE. out_valid with out_ready in the same cycle completes; in_ready rises the next cycle.
- Idle ALU drive: alu_op=ADD, alu_a=0, alu_b=0 in IDLE and DONE.
- Reset, including mid-MUL: state=IDLE, in_ready=1 after reset, out_valid=0, out_res=0, out_zero=0, out_illegal=0, acc/cnt=0. Any in-flight request is discarded.

Decomposition:
- Shared package alu_pkg:
  - localparams ALUOP_AND, ALUOP_OR, ALUOP_ADD, ALUOP_SUB, ALUOP_NOR.
  - ALUOp control codes CTL_MEM, CTL_BR, CTL_R.
  - funct3/funct7 constants.
  - State encoding (2-bit).
- Sub-module alu_decode: purely combinational ctl/funct3/funct7 -> {op[3:0], is_mul, illegal}. The ALU itself is instantiated by the parent datapath, not inside this block.

Test Plan:
1. reset; ctl=10, f3=000, f7=0, a=5, b=7 -> alu_op=0010 in EXEC; out_res=12, out_zero=0 at N+2; held until out_ready.
2. ctl=10, f7=0100000, f3=000, a=9, b=9 -> SUB; out_res=0, out_zero=1. Then ctl=01, a=3, b=5 -> out_res=0xFFFF_FFFF_FFFF_FFFE.
3. f3=111 a=0xF0F0, b=0xFF00 -> 0xF000. f3=110 same operands -> 0xFFF0.
4. MUL a=0x1_0000_0001, b=3 -> out_res=0x3_0000_0003 at N+65. MUL a=2^63, b=2 -> out_res=0, out_zero=1 (wrap).
5. ctl=11, or f3=101 -> out_illegal=1, out_res=0, out_zero=1; ALU never driven with a non-ADD op.
6. Assert reset at MUL iteration 30 -> next cycle in_ready=1, out_valid=0. Also: hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout.
